// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op codes, FSM state encoding, op-class helpers.
package md_pkg;

  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_MULU = 3'b001;
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_DIVU = 3'b011;
  localparam logic [2:0] MD_MTHI = 3'b100;
  localparam logic [2:0] MD_MTLO = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [2:0] code);
    return (code == MD_MUL) || (code == MD_MULU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] code);
    return (code == MD_DIV) || (code == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_lat_cnt.sv
// Latency counter for the MD sequencer: load a start value, count down, flag zero.
module hilo_lat_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: holds MD operands for a fixed latency, commits results, serves MFHI/MFLO.
// Optional macro HILO_BYPASS_EN forwards the MD result on the final busy cycle.
module hilo_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        flush,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [2:0]  md_ctr,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        issue_rdy,
  output logic        busy,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        dz
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e   state;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        cnt_zero;
  logic        accept_md;
  logic        commit;
  logic        div_zero;

  assign accept_md = (state == ST_IDLE) && start && (md_is_mul(op) || md_is_div(op));
  // flush wins over the final-cycle commit
  assign commit    = (state == ST_BUSY) && cnt_zero && !flush;
  assign div_zero  = md_is_div(md_ctr) && (md_b == 32'd0);

  hilo_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_md),
    .load_val(md_is_div(op) ? DIV_LOAD : MUL_LOAD),
    .dec     (state == ST_BUSY),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      md_a   <= '0;
      md_b   <= '0;
      md_ctr <= MD_MUL;
      dz     <= 1'b0;
    end else begin
      dz <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MD_MUL, MD_MULU, MD_DIV, MD_DIVU: begin
                md_a   <= a_in;
                md_b   <= b_in;
                md_ctr <= op;
                state  <= ST_BUSY;
              end
              MD_MTHI: hi_q <= a_in;
              MD_MTLO: lo_q <= a_in;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (flush || cnt_zero) begin
            state <= ST_IDLE;
          end
          if (commit) begin
            if (div_zero) begin
              dz <= 1'b1;
            end else begin
              hi_q <= md_hi;
              lo_q <= md_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign issue_rdy = (state == ST_IDLE);
  assign busy      = (state == ST_BUSY);

`ifdef HILO_BYPASS_EN
  logic fwd;
  assign fwd     = commit && !div_zero;
  assign stall   = rd_req && busy && !commit;
  assign rd_data = fwd ? (rd_sel ? md_hi : md_lo) : (rd_sel ? hi_q : lo_q);
`else
  assign stall   = rd_req && busy;
  assign rd_data = rd_sel ? hi_q : lo_q;
`endif

endmodule
